id_ex_alu_decode: RTL
=====================

# id_ex_alu_decode

Decode-to-execute stage block for the 5-stage pipeline. Decodes the ID-stage instruction into the 4-bit ALU control code and operands consumed by the ALU. Registers them into the ID/EX pipeline register with stall, flush and valid handling. Also keeps a saturating count of instructions rejected as unsupported by the ALU.

## Interface
Parameters:
- CNT_W, 8, width of the illegal-instruction counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_instr  in  32  instruction word in ID
- id_rs1_data  in  32  register-file read of rs1
- id_rs2_data  in  32  register-file read of rs2
- stall  in  1  hold the ID/EX register contents
- flush  in  1  replace the next ID/EX contents with a bubble
- ex_valid  out  1  EX stage holds a real instruction
- ex_in1  out  32  ALU operand 1
- ex_in2  out  32  ALU operand 2
- ex_ctrl  out  4  ALU control code
- ex_rd  out  5  destination register
- ex_wb_en  out  1  EX result is to be written back
- ex_illegal  out  1  instruction in EX was rejected
- illegal_cnt  out  CNT_W  saturating count of rejected instructions

## Operation
ALU control codes:
- 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND
- 5 SLL by exactly 1, 6 SRL by exactly 1

R-type (opcode 0110011), in1=rs1_data, in2=rs2_data:
- funct3 000 with funct7 0000000 -> ADD; with funct7 0100000 -> SUB
- funct3 100 -> XOR, 110 -> OR, 111 -> AND; each requires funct7 0000000

I-type (opcode 0010011), in1=rs1_data, in2=sign-extended instr[31:20]:
- funct3 000 -> ADD, 100 -> XOR, 110 -> OR, 111 -> AND
- funct3 001 (SLLI) is legal only with instr[31:25]=0 and shamt=1 -> ctrl 5
- funct3 101 (SRLI) is legal only with instr[31:25]=0 and shamt=1 -> ctrl 6

Illegal instructions:
- Every other encoding is illegal, including R-type SLL/SRL, any shamt other than 1, SRAI/SRA, SLT/SLTU and all other opcodes.
- An illegal instruction with id_valid=1 loads: ex_valid=1, ex_illegal=1, ex_ctrl=0, ex_wb_en=0, in1=in2=0, ex_rd=instr[11:7].

Write-back and bubbles:
- ex_wb_en = legal & id_valid & (rd != 0).
- Bubble contents: ex_valid=0, ex_wb_en=0, ex_illegal=0, ex_ctrl=0, in1=in2=0, ex_rd=0.
- id_valid=0 loads a bubble.

Illegal counter:
- illegal_cnt increments when a valid illegal instruction is loaded into ID/EX.
- It does not count while stalled or on a flushed slot.
- It saturates at 2^CNT_W-1.

## Timing
- Latency is 1 cycle: ID inputs sampled at edge N appear on the ex_* outputs after edge N.
- Reset sets every output to 0, including illegal_cnt. rst overrides stall and flush. Reset mid-stall discards the held instruction.
- stall=1, flush=0: all ex_* outputs and illegal_cnt hold their values.
- flush=1: a bubble is loaded. flush takes priority over stall.
- stall=0, flush=0: the decoded ID instruction is loaded.
- Outputs are purely registered. There is no combinational path from inputs to ex_*.
- illegal_cnt updates on the same edge that loads the illegal instruction.

## Structure
- Shared package alu_pkg holds:
  - ALU control code localparams (ALU_ADD..ALU_SRL = 0..6)
  - opcode constants OP_R=7'b0110011 and OP_I=7'b0010011
  - funct3/funct7 constants
- The existing ALU also moves to these constants.
- The block has one combinational sub-module, alu_ctrl_dec: input instr; outputs ctrl, legal, use_imm, imm.
- id_ex_alu_decode instantiates alu_ctrl_dec and contains the register, the operand mux and the counter.

## Test plan
- Reset with stall=1 and flush=1 asserted: all outputs read 0 after the edge; illegal_cnt=0.
- R-type SUB (0x40208033, rd=0) with rs1=10, rs2=3 -> next cycle ex_ctrl=1, in1=10, in2=3, ex_valid=1, ex_wb_en=0 because rd=0.
- ADDI x5,x1,-1 (0xFFF08293) with rs1=7 -> ex_ctrl=0, in2=0xFFFFFFFF, ex_rd=5, ex_wb_en=1.
- SLLI x3,x3,1 -> ex_ctrl=5, ex_wb_en=1. SLLI x3,x3,2 -> ex_illegal=1, ex_wb_en=0, illegal_cnt increments by 1.
- ADD issued, then stall=1 held for 3 cycles -> outputs unchanged for those cycles. Then stall=1 and flush=1 together -> bubble loaded, illegal_cnt unchanged.
- 300 consecutive valid illegal instructions with CNT_W=8 -> illegal_cnt stops at 255 and holds there.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, opcodes and funct fields used by the
// decode stage and the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] SHAMT_ONE = 5'd1;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of an instruction word into ALU control, legality,
// operand-2 select and the sign-extended I-type immediate.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  ctrl,
  output logic        legal,
  output logic        use_imm,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] shamt;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign shamt  = instr[24:20];
  assign imm    = sext12(instr[31:20]);

  // rs1/rd fields are handled by the register file and the pipeline register
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  always_comb begin
    ctrl    = ALU_ADD;
    legal   = 1'b0;
    use_imm = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_BASE) begin
              legal = 1'b1;
              ctrl  = ALU_ADD;
            end else if (funct7 == F7_ALT) begin
              legal = 1'b1;
              ctrl  = ALU_SUB;
            end
          end
          F3_XOR: if (funct7 == F7_BASE) begin legal = 1'b1; ctrl = ALU_XOR; end
          F3_OR:  if (funct7 == F7_BASE) begin legal = 1'b1; ctrl = ALU_OR;  end
          F3_AND: if (funct7 == F7_BASE) begin legal = 1'b1; ctrl = ALU_AND; end
          default: ;
        endcase
      end
      OP_I: begin
        use_imm = 1'b1;
        case (funct3)
          F3_ADD: begin legal = 1'b1; ctrl = ALU_ADD; end
          F3_XOR: begin legal = 1'b1; ctrl = ALU_XOR; end
          F3_OR:  begin legal = 1'b1; ctrl = ALU_OR;  end
          F3_AND: begin legal = 1'b1; ctrl = ALU_AND; end
          // the ALU only has a fixed single-bit shifter
          F3_SLL: if (funct7 == F7_BASE && shamt == SHAMT_ONE) begin legal = 1'b1; ctrl = ALU_SLL; end
          F3_SRL: if (funct7 == F7_BASE && shamt == SHAMT_ONE) begin legal = 1'b1; ctrl = ALU_SRL; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_decode.sv
// ID/EX pipeline register: decodes the ID instruction into ALU control and
// operands, with stall/flush handling and a saturating illegal-op counter.
module id_ex_alu_decode
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_rs1_data,
  input  logic [31:0]      id_rs2_data,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [31:0]      ex_in1,
  output logic [31:0]      ex_in2,
  output logic [3:0]       ex_ctrl,
  output logic [4:0]       ex_rd,
  output logic             ex_wb_en,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]  dec_ctrl;
  logic        dec_legal;
  logic        dec_use_imm;
  logic [31:0] dec_imm;

  logic        ok;
  logic        bad;
  logic [4:0]  rd;
  logic [31:0] nx_in1;
  logic [31:0] nx_in2;
  logic [3:0]  nx_ctrl;
  logic [4:0]  nx_rd;
  logic        nx_wb_en;
  logic        load;

  alu_ctrl_dec u_dec (
    .instr   (id_instr),
    .ctrl    (dec_ctrl),
    .legal   (dec_legal),
    .use_imm (dec_use_imm),
    .imm     (dec_imm)
  );

  assign rd   = id_instr[11:7];
  assign ok   = id_valid & dec_legal;
  assign bad  = id_valid & ~dec_legal;
  assign load = ~stall & ~flush;

  // illegal and invalid slots carry zeroed operands so the ALU sees a no-op
  always_comb begin
    nx_in1   = ok ? id_rs1_data : 32'd0;
    nx_in2   = ok ? (dec_use_imm ? dec_imm : id_rs2_data) : 32'd0;
    nx_ctrl  = ok ? dec_ctrl : ALU_ADD;
    nx_rd    = id_valid ? rd : 5'd0;
    nx_wb_en = ok & (rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid   <= 1'b0;
      ex_in1     <= 32'd0;
      ex_in2     <= 32'd0;
      ex_ctrl    <= ALU_ADD;
      ex_rd      <= 5'd0;
      ex_wb_en   <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      ex_in1     <= nx_in1;
      ex_in2     <= nx_in2;
      ex_ctrl    <= nx_ctrl;
      ex_rd      <= nx_rd;
      ex_wb_en   <= nx_wb_en;
      ex_illegal <= bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      illegal_cnt <= '0;
    else if (load && bad && illegal_cnt != CNT_MAX)
      illegal_cnt <= illegal_cnt + CNT_W'(1);
  end

endmodule
